// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_pkg
// Description : Shared constants and FSM encoding for the ALU command
//               sequencer (unit selects, state type, stats counter width).
// Revision    : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

  // Unit select carried in ALU_FUN[3:2]
  localparam logic [1:0] UNIT_ARITH = 2'b00;
  localparam logic [1:0] UNIT_LOGIC = 2'b01;
  localparam logic [1:0] UNIT_CMP   = 2'b10;
  localparam logic [1:0] UNIT_SHIFT = 2'b11;

  // Width of the optional operation / error tallies
  localparam int STATS_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/alu_cmd_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_cmd_sequencer_if
// Description : Command channel, ALU operand/result bus and response channel
//               of the ALU command sequencer. The master modport is the
//               sequencer; the slave modport is the front end plus ALU side.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_cmd_sequencer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int FUN_WIDTH  = 4,
  parameter int CMP_WIDTH  = 4
);
  // Command channel
  logic                  CMD_VALID;
  logic                  CMD_READY;
  logic [DATA_WIDTH-1:0] CMD_A;
  logic [DATA_WIDTH-1:0] CMD_B;
  logic [FUN_WIDTH-1:0]  CMD_FUN;
  // ALU operands
  logic [DATA_WIDTH-1:0] A;
  logic [DATA_WIDTH-1:0] B;
  logic [FUN_WIDTH-1:0]  ALU_FUN;
  // ALU results and flags
  logic [DATA_WIDTH-1:0] Arith_OUT;
  logic [DATA_WIDTH-1:0] Logic_OUT;
  logic [DATA_WIDTH-1:0] SHIFT_OUT;
  logic [CMP_WIDTH-1:0]  CMP_OUT;
  logic                  Carry_OUT;
  logic                  Arith_Flag;
  logic                  Logic_Flag;
  logic                  CMP_Flag;
  logic                  SHIFT_Flag;
  // Response channel
  logic                  RSP_VALID;
  logic                  RSP_READY;
  logic [DATA_WIDTH-1:0] RSP_DATA;
  logic                  RSP_CARRY;
  logic [1:0]            RSP_UNIT;
  logic                  RSP_ERR;

  modport master (
    input  CMD_VALID, CMD_A, CMD_B, CMD_FUN,
    output CMD_READY,
    output A, B, ALU_FUN,
    input  Arith_OUT, Logic_OUT, SHIFT_OUT, CMP_OUT, Carry_OUT,
    input  Arith_Flag, Logic_Flag, CMP_Flag, SHIFT_Flag,
    output RSP_VALID, RSP_DATA, RSP_CARRY, RSP_UNIT, RSP_ERR,
    input  RSP_READY
  );

  modport slave (
    output CMD_VALID, CMD_A, CMD_B, CMD_FUN,
    input  CMD_READY,
    input  A, B, ALU_FUN,
    output Arith_OUT, Logic_OUT, SHIFT_OUT, CMP_OUT, Carry_OUT,
    output Arith_Flag, Logic_Flag, CMP_Flag, SHIFT_Flag,
    input  RSP_VALID, RSP_DATA, RSP_CARRY, RSP_UNIT, RSP_ERR,
    output RSP_READY
  );

endinterface
`default_nettype wire

// File: rtl/alu_seq_result_mux.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_result_mux
// Description : Selects result, carry and result-valid flag of the ALU unit
//               addressed by the unit select; compare result is zero-extended.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_result_mux
  import alu_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int CMP_WIDTH  = 4
) (
  input  wire logic [1:0]            i_unit_sel,
  input  wire logic [DATA_WIDTH-1:0] i_arith_out,
  input  wire logic [DATA_WIDTH-1:0] i_logic_out,
  input  wire logic [DATA_WIDTH-1:0] i_shift_out,
  input  wire logic [CMP_WIDTH-1:0]  i_cmp_out,
  input  wire logic                  i_carry_out,
  input  wire logic                  i_arith_flag,
  input  wire logic                  i_logic_flag,
  input  wire logic                  i_cmp_flag,
  input  wire logic                  i_shift_flag,
  output logic      [DATA_WIDTH-1:0] o_sel_data,
  output logic                       o_sel_carry,
  output logic                       o_sel_flag
);

  // Route the addressed unit; carry only has meaning for the arithmetic unit
  always_comb begin
    o_sel_data  = i_arith_out;
    o_sel_carry = 1'b0;
    o_sel_flag  = 1'b0;
    case (i_unit_sel)
      UNIT_ARITH: begin
        o_sel_data  = i_arith_out;
        o_sel_carry = i_carry_out;
        o_sel_flag  = i_arith_flag;
      end
      UNIT_LOGIC: begin
        o_sel_data = i_logic_out;
        o_sel_flag = i_logic_flag;
      end
      UNIT_CMP: begin
        o_sel_data = DATA_WIDTH'(i_cmp_out);
        o_sel_flag = i_cmp_flag;
      end
      default: begin
        o_sel_data = i_shift_out;
        o_sel_flag = i_shift_flag;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_cmd_sequencer
// Description : Issues one command per handshake to the ALU, waits for the
//               selected unit's flag (with timeout) and returns the captured
//               result on a valid/ready response channel.
//               Optional macro ALU_SEQ_STATS_EN adds OP_COUNT / ERR_COUNT.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int FUN_WIDTH   = 4,
  parameter int CMP_WIDTH   = 4,
  parameter int TIMEOUT_CYC = 8
) (
  input  wire logic            CLK,
  input  wire logic            RST,
  alu_cmd_sequencer_if.master  bus
`ifdef ALU_SEQ_STATS_EN
  ,
  output logic [STATS_WIDTH-1:0] OP_COUNT,
  output logic [STATS_WIDTH-1:0] ERR_COUNT
`endif
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;

  seq_state_t            r_state;
  logic                  r_cmd_ready;
  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;
  logic [FUN_WIDTH-1:0]  r_alu_fun;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_data;
  logic                  r_rsp_carry;
  logic [1:0]            r_rsp_unit;
  logic                  r_rsp_err;

  logic [1:0]            w_unit;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic                  w_sel_carry;
  logic                  w_sel_flag;

  assign w_unit = r_alu_fun[FUN_WIDTH-1 -: 2];

  alu_seq_result_mux #(
    .DATA_WIDTH (DATA_WIDTH),
    .CMP_WIDTH  (CMP_WIDTH)
  ) u_result_mux (
    .i_unit_sel   (w_unit),
    .i_arith_out  (bus.Arith_OUT),
    .i_logic_out  (bus.Logic_OUT),
    .i_shift_out  (bus.SHIFT_OUT),
    .i_cmp_out    (bus.CMP_OUT),
    .i_carry_out  (bus.Carry_OUT),
    .i_arith_flag (bus.Arith_Flag),
    .i_logic_flag (bus.Logic_Flag),
    .i_cmp_flag   (bus.CMP_Flag),
    .i_shift_flag (bus.SHIFT_Flag),
    .o_sel_data   (w_sel_data),
    .o_sel_carry  (w_sel_carry),
    .o_sel_flag   (w_sel_flag)
  );

  // Command FSM: accept, hold operands one cycle, wait for flag, respond
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state     <= IDLE;
      r_cmd_ready <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_alu_fun   <= '0;
      r_cnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_carry <= 1'b0;
      r_rsp_unit  <= 2'b00;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.CMD_VALID && r_cmd_ready) begin
            r_a         <= bus.CMD_A;
            r_b         <= bus.CMD_B;
            r_alu_fun   <= bus.CMD_FUN;
            r_cmd_ready <= 1'b0;
            r_state     <= ISSUE;
          end else begin
            r_cmd_ready <= 1'b1;
          end
        end
        ISSUE: begin
          // The ALU registers its result at the end of this cycle, so any
          // flag seen from here on belongs to the current command.
          r_cnt   <= '0;
          r_state <= WAIT;
        end
        WAIT: begin
          if (w_sel_flag) begin
            r_rsp_data  <= w_sel_data;
            r_rsp_carry <= w_sel_carry;
            r_rsp_unit  <= w_unit;
            r_rsp_err   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end else if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            r_rsp_data  <= '0;
            r_rsp_carry <= 1'b0;
            r_rsp_unit  <= w_unit;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        RESP: begin
          if (bus.RSP_READY) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.CMD_READY = r_cmd_ready;
  assign bus.A         = r_a;
  assign bus.B         = r_b;
  assign bus.ALU_FUN   = r_alu_fun;
  assign bus.RSP_VALID = r_rsp_valid;
  assign bus.RSP_DATA  = r_rsp_data;
  assign bus.RSP_CARRY = r_rsp_carry;
  assign bus.RSP_UNIT  = r_rsp_unit;
  assign bus.RSP_ERR   = r_rsp_err;

`ifdef ALU_SEQ_STATS_EN
  logic [STATS_WIDTH-1:0] r_op_count;
  logic [STATS_WIDTH-1:0] r_err_count;
  logic                   w_rsp_fire;

  assign w_rsp_fire = r_rsp_valid && bus.RSP_READY;

  // Saturating tallies of completed responses and of timed-out responses
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_op_count  <= '0;
      r_err_count <= '0;
    end else if (w_rsp_fire) begin
      if (r_op_count != {STATS_WIDTH{1'b1}}) begin
        r_op_count <= r_op_count + STATS_WIDTH'(1);
      end
      if (r_rsp_err && (r_err_count != {STATS_WIDTH{1'b1}})) begin
        r_err_count <= r_err_count + STATS_WIDTH'(1);
      end
    end
  end

  assign OP_COUNT  = r_op_count;
  assign ERR_COUNT = r_err_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_cmd_sequencer
// Description : Scoreboard bench for alu_cmd_sequencer with a behavioural ALU
//               responder (results and flags registered one cycle after the
//               operands). Honours ALU_SEQ_STATS_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_cmd_sequencer;
  import alu_seq_pkg::*;

  localparam int DW = 16;
  localparam int FW = 4;
  localparam int CW = 4;
  localparam int TO = 8;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  alu_cmd_sequencer_if #(.DATA_WIDTH(DW), .FUN_WIDTH(FW), .CMP_WIDTH(CW)) bus ();

`ifdef ALU_SEQ_STATS_EN
  logic [7:0] op_count;
  logic [7:0] err_count;
`endif

  alu_cmd_sequencer #(
    .DATA_WIDTH  (DW),
    .FUN_WIDTH   (FW),
    .CMP_WIDTH   (CW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
`ifdef ALU_SEQ_STATS_EN
    .OP_COUNT  (op_count),
    .ERR_COUNT (err_count),
`endif
    .bus       (bus)
  );

  // Behavioural ALU responder
  logic suppress_shift = 1'b0;
  logic toggle_others  = 1'b0;
  logic tog;
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      bus.Arith_OUT  <= '0;
      bus.Carry_OUT  <= 1'b0;
      bus.Logic_OUT  <= '0;
      bus.SHIFT_OUT  <= '0;
      bus.CMP_OUT    <= '0;
      bus.Arith_Flag <= 1'b0;
      bus.Logic_Flag <= 1'b0;
      bus.CMP_Flag   <= 1'b0;
      bus.SHIFT_Flag <= 1'b0;
      tog            <= 1'b0;
    end else begin
      {bus.Carry_OUT, bus.Arith_OUT} <= {1'b0, bus.A} + {1'b0, bus.B};
      bus.Logic_OUT  <= bus.A ^ bus.B;
      bus.SHIFT_OUT  <= bus.A << 1;
      bus.CMP_OUT    <= 4'hA;
      tog            <= ~tog;
      bus.Arith_Flag <= (bus.ALU_FUN[3:2] == 2'b00) | (toggle_others & tog);
      bus.Logic_Flag <= (bus.ALU_FUN[3:2] == 2'b01) | (toggle_others & tog);
      bus.CMP_Flag   <= (bus.ALU_FUN[3:2] == 2'b10) | (toggle_others & tog);
      bus.SHIFT_Flag <= (bus.ALU_FUN[3:2] == 2'b11) & ~suppress_shift;
    end
  end

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] data;
    logic        carry;
    logic [1:0]  unit;
    logic        err;
    int          t_valid;
  } exp_t;
  exp_t q[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic send(input logic [15:0] a, input logic [15:0] b,
                      input logic [3:0] fun, output int hs);
    bus.CMD_VALID = 1'b1;
    bus.CMD_A     = a;
    bus.CMD_B     = b;
    bus.CMD_FUN   = fun;
    hs = -1;
    for (int i = 0; i < 40; i++) begin
      if (bus.CMD_READY === 1'b1) begin
        hs = cyc + 1;
        break;
      end
      @(negedge CLK);
    end
    if (hs < 0) check("cmd_accept_timeout", bus.CMD_READY, 1);
    @(negedge CLK);
    bus.CMD_VALID = 1'b0;
  endtask

  task automatic push(input logic [15:0] d, input logic c, input logic [1:0] u,
                      input logic e, input int hs, input int lat);
    exp_t x;
    x.data = d; x.carry = c; x.unit = u; x.err = e; x.t_valid = hs + lat - 1;
    q.push_back(x);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 60) begin
      @(negedge CLK);
      n++;
    end
    check("drain", q.size(), 0);
  endtask

  // Monitor: samples just before each rising edge
  logic mon_prev_v = 1'b0;
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      #4;
      if (RST !== 1'b1) begin
        mon_prev_v = 1'b0;
      end else begin
        if (bus.RSP_VALID && !mon_prev_v) begin
          if (q.size() == 0) check("rsp_unexpected", bus.RSP_VALID, 0);
          else               check("rsp_latency", cyc, q[0].t_valid);
        end
        if (bus.RSP_VALID && bus.RSP_READY && q.size() != 0) begin
          e = q.pop_front();
          check("rsp_data",  bus.RSP_DATA,  e.data);
          check("rsp_carry", bus.RSP_CARRY, e.carry);
          check("rsp_unit",  bus.RSP_UNIT,  e.unit);
          check("rsp_err",   bus.RSP_ERR,   e.err);
        end
        mon_prev_v = bus.RSP_VALID;
      end
    end
  end

  initial begin
    int h1, h2;
    logic seen;
    bus.CMD_VALID = 1'b0;
    bus.CMD_A     = '0;
    bus.CMD_B     = '0;
    bus.CMD_FUN   = '0;
    bus.RSP_READY = 1'b1;

    // Reset with a command pending
    #2 RST = 1'b0;
    bus.CMD_VALID = 1'b1;
    bus.CMD_A     = 16'h1234;
    bus.CMD_B     = 16'h4321;
    bus.CMD_FUN   = 4'b0100;
    repeat (3) @(negedge CLK);
    check("rst_cmd_ready", bus.CMD_READY, 0);
    check("rst_rsp_valid", bus.RSP_VALID, 0);
    check("rst_a",         bus.A, 0);
    check("rst_b",         bus.B, 0);
    check("rst_alu_fun",   bus.ALU_FUN, 0);
    bus.CMD_VALID = 1'b0;
    RST = 1'b1;
    @(posedge CLK);
    #1 check("ready_after_release", bus.CMD_READY, 1);
`ifdef ALU_SEQ_STATS_EN
    check("rst_op_count", op_count, 0);
`endif
    @(negedge CLK);

    // Arithmetic then compare back-to-back
    send(16'hFFFF, 16'h0002, 4'b0000, h1);
    push(16'h0001, 1'b1, 2'd0, 1'b0, h1, 3);
    send(16'h1234, 16'h5678, 4'b1001, h2);
    push(16'h000A, 1'b0, 2'd2, 1'b0, h2, 3);
    check("throughput", h2 - h1, 4);
    drain();

    // Backpressure on a logic command, then a shift command
    bus.RSP_READY = 1'b0;
    send(16'hF0F0, 16'hFF00, 4'b0100, h1);
    push(16'h0FF0, 1'b0, 2'd1, 1'b0, h1, 3);
    for (int i = 0; i < 20 && bus.RSP_VALID !== 1'b1; i++) @(negedge CLK);
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_valid", bus.RSP_VALID, 1);
      check("bp_rsp_data",  bus.RSP_DATA, 16'h0FF0);
      check("bp_cmd_ready", bus.CMD_READY, 0);
      @(negedge CLK);
    end
    bus.RSP_READY = 1'b1;
    @(negedge CLK);
    check("bp_idle_ready", bus.CMD_READY, 1);
    check("bp_idle_valid", bus.RSP_VALID, 0);
    send(16'h0123, 16'h0000, 4'b1100, h2);
    push(16'h0246, 1'b0, 2'd3, 1'b0, h2, 3);
    drain();

    // Timeout with the shift flag suppressed and other flags toggling
    suppress_shift = 1'b1;
    toggle_others  = 1'b1;
    send(16'hFFFF, 16'h0001, 4'b1100, h1);
    push(16'h0000, 1'b0, 2'd3, 1'b1, h1, 2 + TO);
    drain();
    toggle_others = 1'b0;
`ifdef ALU_SEQ_STATS_EN
    check("op_count",  op_count, 5);
    check("err_count", err_count, 1);
`endif

    // Reset while waiting: command discarded, no response
    send(16'h0001, 16'h0001, 4'b1100, h1);
    repeat (2) @(negedge CLK);
    #1 RST = 1'b0;
    #1;
    check("midrst_a",         bus.A, 0);
    check("midrst_b",         bus.B, 0);
    check("midrst_alu_fun",   bus.ALU_FUN, 0);
    check("midrst_rsp_valid", bus.RSP_VALID, 0);
`ifdef ALU_SEQ_STATS_EN
    check("midrst_op_count", op_count, 0);
`endif
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    suppress_shift = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (bus.RSP_VALID === 1'b1) seen = 1'b1;
    end
    check("midrst_no_rsp", seen, 0);

    // Recovery after reset
    send(16'h0005, 16'h0003, 4'b0001, h1);
    push(16'h0008, 1'b0, 2'd0, 1'b0, h1, 3);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Command-side master for the ALU top. Accepts one operation per valid/ready handshake and drives the ALU's A, B and ALU_FUN inputs.
- Waits for the selected unit's registered flag, captures that unit's result, and returns it on a valid/ready response channel.
- Sits between the bus/CPU front end and the ALU top; it is the issuing end of the ALU operand/result interface.

Parameters:
- DATA_WIDTH, 16, width of A, B and all 16-bit unit results
- FUN_WIDTH, 4, ALU_FUN width; bits [3:2] are the unit select, bits [1:0] the operation
- CMP_WIDTH, 4, width of CMP_OUT
- TIMEOUT_CYC, 8, maximum WAIT cycles before an error response (minimum 1)

Ports:
- CLK  in  1  clock; all state updates on the rising edge
- RST  in  1  asynchronous, active-low reset
- CMD_VALID  in  1  command present
- CMD_READY  out  1  sequencer can accept a command
- CMD_A  in  DATA_WIDTH  operand A
- CMD_B  in  DATA_WIDTH  operand B
- CMD_FUN  in  FUN_WIDTH  operation code
- A  out  DATA_WIDTH  to ALU
- B  out  DATA_WIDTH  to ALU
- ALU_FUN  out  FUN_WIDTH  to ALU
- Arith_OUT, Logic_OUT, SHIFT_OUT  in  DATA_WIDTH  unit results
- CMP_OUT  in  CMP_WIDTH  compare result
- Carry_OUT  in  1  arithmetic carry
- Arith_Flag, Logic_Flag, CMP_Flag, SHIFT_Flag  in  1  unit result-valid flags
- RSP_VALID  out  1  response present
- RSP_READY  in  1  response consumer ready
- RSP_DATA  out  DATA_WIDTH  captured result
- RSP_CARRY  out  1  captured Carry_OUT; 0 for non-arithmetic units
- RSP_UNIT  out  2  CMD_FUN[3:2] of the completed command
- RSP_ERR  out  1  timeout occurred

Behaviour:
- Unit select from FUN[3:2]:
  - 00 arithmetic
  - 01 logic
  - 10 compare
  - 11 shift
- Reset (RST low, asynchronous):
  - state=IDLE
  - CMD_READY=0 while RST low, 1 in the first cycle after release
  - A, B, ALU_FUN=0
  - RSP_VALID=0; RSP_DATA, RSP_CARRY, RSP_UNIT, RSP_ERR=0
  - timeout counter=0
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - CMD_READY=1.
  - On CMD_VALID&CMD_READY, register CMD_A/B/FUN into A/B/ALU_FUN, go to ISSUE.
- ISSUE (exactly 1 cycle):
  - CMD_READY=0; A/B/ALU_FUN held stable.
  - The ALU registers its result at the end of this cycle; go to WAIT with counter cleared.
- WAIT:
  - Each cycle, sample the flag of the selected unit.
  - Flag=1: capture the selected result into RSP_DATA.
    - CMP_OUT is zero-extended to DATA_WIDTH.
    - RSP_CARRY=Carry_OUT only for the arithmetic unit, else 0.
    - RSP_ERR=0; go to RESP.
  - Flag=0: increment counter. When the counter reaches TIMEOUT_CYC, set RSP_DATA=0, RSP_CARRY=0, RSP_ERR=1, go to RESP.
  - Flags of non-selected units are ignored.
- RESP:
  - RSP_VALID=1; RSP_* held stable until RSP_READY.
  - On RSP_VALID&RSP_READY, clear RSP_VALID and go to IDLE.
  - CMD_READY=0 throughout RESP.
- Latency:
  - Handshake at cycle 0 → ISSUE at cycle 1 → WAIT at cycle 2.
  - Flag already high in the first WAIT cycle → RSP_VALID at cycle 3.
  - Back-to-back throughput: one command per 4 cycles when RSP_READY is held high.
- A, B and ALU_FUN keep the last command's values in IDLE; they are never changed outside the IDLE→ISSUE transition.
- A stale flag from a previous command cannot be sampled, because ISSUE always precedes WAIT.
- CMD_VALID while not ready: the command is ignored (not accepted); the source must hold it.
- RST asserted mid-operation: immediate return to reset values; the in-flight command is discarded and no response is produced.

Optional Feature:
- Macro: ALU_SEQ_STATS_EN.
- With the macro defined:
  - Extra outputs OP_COUNT[7:0] and ERR_COUNT[7:0].
  - OP_COUNT increments on each response handshake; ERR_COUNT increments on each handshake with RSP_ERR=1.
  - Both counters saturate at 8'hFF and reset to 0.
- Without the macro: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package alu_seq_pkg:
  - unit-select constants UNIT_ARITH=2'b00, UNIT_LOGIC=2'b01, UNIT_CMP=2'b10, UNIT_SHIFT=2'b11
  - FSM state encoding: IDLE, ISSUE, WAIT, RESP
  - stats counter width 8
- One sub-module, alu_seq_result_mux: combinational selection of result, carry and flag by unit select, including CMP zero-extension.

Test Plan:
- The bench uses a behavioural ALU responder stub:
  - outputs and flags registered one cycle after A/B/ALU_FUN
  - arithmetic result = A+B with carry
  - compare result = 4'hA
- Reset: hold RST low for 3 cycles with CMD_VALID=1 → CMD_READY=0, RSP_VALID=0, A=B=0; CMD_READY=1 in the first cycle after release.
- Arithmetic: A=16'hFFFF, B=16'h0002, FUN=4'b0000 → RSP_VALID 3 cycles after the handshake, RSP_DATA=16'h0001, RSP_CARRY=1, RSP_UNIT=0, RSP_ERR=0.
- Compare: FUN=4'b1001 → RSP_DATA=16'h000A, RSP_CARRY=0, RSP_UNIT=2.
- Timeout: stub suppresses SHIFT_Flag, FUN=4'b1100 → RSP_ERR=1, RSP_DATA=0 after 1+1+TIMEOUT_CYC cycles; all other unit flags toggling high has no effect.
- Backpressure: hold RSP_READY=0 for 5 cycles → RSP_* stable and CMD_READY=0 throughout; release → IDLE next cycle, second command accepted.
- Mid-op reset: assert RST in WAIT → RSP_VALID never asserts, A/B/ALU_FUN=0 immediately; with ALU_SEQ_STATS_EN, OP_COUNT=0.
